// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive paths.
// Defining UART_TX_PARITY_EN adds an even-parity bit to every transmitted frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_divisor(input int clock_frequency, input int desired_baud_rate);
        return (clock_frequency + desired_baud_rate / 2) / desired_baud_rate;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with push/pop, full/empty and occupancy.
// Shared by the UART transmit and receive paths.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;

    if (Depth < 2 || Depth > 256 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
        $error("uart_fifo: Depth %0d must be a power of two in 2..256", Depth);
    end

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (r_level == LW'(Depth));
    assign empty_o   = (r_level == '0);
    assign level_o   = r_level;
    assign data_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    // NOTE: storage has no reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values whatever the block order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte stream into a FIFO, serialised on tx_o.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int ClockFrequency  = 12_000_000,
    parameter int DesiredBaudRate = 9_600,
    parameter int FifoDepth       = 8,
    parameter int DataWidth       = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DataWidth-1:0]         data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   level_o
);

    localparam int DIVISOR = calc_divisor(ClockFrequency, DesiredBaudRate);
    localparam int BAUD_W  = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
    localparam int BIT_W   = $clog2(DataWidth);

    if (DIVISOR < 2) begin : g_divisor_check
        $error("uart_tx_fifo: baud divisor %0d is below 2", DIVISOR);
    end
    if (DataWidth != 8) begin : g_width_check
        $error("uart_tx_fifo: DataWidth must be 8, got %0d", DataWidth);
    end

    tx_state_e            r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit;
    logic [DataWidth-1:0] r_shift;
    logic                 r_tx;

    logic [DataWidth-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_done;

    assign ready_o     = ~w_full;
    assign w_push      = valid_i & ~w_full;
    assign w_baud_done = (r_baud == BAUD_W'(DIVISOR - 1));
    // A new byte is taken either from idle or on the last cycle of a stop bit, so frames abut.
    assign w_pop       = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_baud_done));
    assign tx_o        = r_tx;
    assign busy_o      = (r_state != IDLE) | (level_o != '0);

    uart_fifo #(
        .Depth (FifoDepth),
        .Width (DataWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (data_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_baud <= '0;
        end else if (r_state == IDLE || w_baud_done) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + BAUD_W'(1);
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // The line flop follows the state one cycle later, keeping tx_o glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= START;
                    end
                end
                START: begin
                    r_tx <= 1'b0;
                    if (w_baud_done) begin
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_tx <= r_shift[0];
                    if (w_baud_done) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + BIT_W'(1);
                        if (r_bit == BIT_W'(DataWidth - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    r_tx <= r_parity;
                    if (w_baud_done) begin
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= START;
                    end else if (w_baud_done) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based line model compared every cycle,
// plus directed literal checks and randomized traffic. Uses a small divisor for speed.
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 60;
    localparam int BAUD   = 10;
    localparam int DEPTH  = 8;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME  = 11;
`else
    localparam int FRAME  = 10;
`endif
    localparam int FRAME_CYC = FRAME * DIV;

    logic       clk     = 1'b0;
    logic       rst_i   = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [3:0] level_o;

    uart_tx_fifo #(
        .ClockFrequency  (CLK_HZ),
        .DesiredBaudRate (BAUD),
        .FifoDepth       (DEPTH),
        .DataWidth       (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .level_o (level_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Behavioural model: pending bytes in a queue, the active frame as a bit vector
    // indexed by elapsed cycles / DIV; the line flop reflects the previous cycle.
    logic [7:0]       m_q[$];
    bit               m_active = 1'b0;
    int               m_c      = 0;
    logic [FRAME-1:0] m_bits   = '1;
    logic             m_tx     = 1'b1;

    function automatic logic [FRAME-1:0] frame_of(input logic [7:0] b);
        logic [FRAME-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    initial begin
        int pre;
        forever begin
            @(posedge clk or posedge rst_i);
            if (rst_i) begin
                m_q.delete();
                m_active = 1'b0;
                m_c      = 0;
                m_tx     = 1'b1;
            end else begin
                pre  = m_q.size();
                m_tx = m_active ? m_bits[m_c / DIV] : 1'b1;
                if (m_active) begin
                    m_c++;
                    if (m_c == FRAME_CYC) m_active = 1'b0;
                end
                if (!m_active && m_q.size() != 0) begin
                    m_bits   = frame_of(m_q.pop_front());
                    m_c      = 0;
                    m_active = 1'b1;
                end
                if (valid_i && pre < DEPTH) m_q.push_back(data_i);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tx_o", tx_o, m_tx);
                check("ready_o", ready_o, m_q.size() < DEPTH);
                check("level_o", level_o, m_q.size());
                check("busy_o", busy_o, m_active || m_q.size() != 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] b);
        valid_i = 1'b1;
        data_i  = b;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_fall(output int lat);
        lat = 0;
        while (tx_o !== 1'b0 && lat < 4 * FRAME_CYC) begin
            tick();
            lat++;
        end
        if (tx_o !== 1'b0) check("tx_fall_timeout", tx_o, 0);
    endtask

    task automatic sample_frame(output logic [FRAME-1:0] s);
        repeat (DIV / 2) tick();
        s[0] = tx_o;
        for (int i = 1; i < FRAME; i++) begin
            repeat (DIV) tick();
            s[i] = tx_o;
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (busy_o && n < limit) begin
            tick();
            n++;
        end
        check("drain_busy", busy_o, 0);
        tick();
    endtask

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int               lat;
        int unsigned      t0;
        int unsigned      prev;
        int               n;
        int               zeros;
        bit               saw_full;
        bit               rose_checked;
        logic [FRAME-1:0] s;
        logic [FRAME-1:0] exp55;
        logic [7:0]       seq [3];
        int               rate;

`ifdef UART_TX_PARITY_EN
        exp55 = 11'b10010101010;
`else
        exp55 = 10'b1010101010;
`endif

        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_tx", tx_o, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_level", level_o, 0);
        check("calc_divisor_default", uart_pkg::calc_divisor(12_000_000, 9_600), 1250);
        rst_i = 1'b0;
        tick();
        tick();

        // Single byte 0x55
        push_one(8'h55);
        t0 = cyc;
        check("level_after_push", level_o, 1);
        wait_fall(lat);
        check("latency_0x55", lat, 2);
        sample_frame(s);
        check("frame_0x55", s, exp55);
        n = 0;
        while (busy_o && n < 2 * FRAME_CYC) begin
            tick();
            n++;
        end
        check("busy_span_0x55", cyc - t0, FRAME_CYC + 1);
        check("idle_busy", busy_o, 0);
        check("idle_tx", tx_o, 1);
        tick();

        // Three bytes back-to-back: contiguous frames, in order
        seq[0] = 8'hA5;
        seq[1] = 8'h3C;
        seq[2] = 8'hFF;
        valid_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            data_i = seq[j];
            tick();
        end
        valid_i = 1'b0;
        prev = 0;
        for (int j = 0; j < 3; j++) begin
            wait_fall(lat);
            if (j > 0) check("frame_gap", cyc - prev, FRAME_CYC);
            prev = cyc;
            sample_frame(s);
            check("b2b_byte", s[8:1], seq[j]);
            check("b2b_stop", s[FRAME-1], 1);
        end
        drain(4 * FRAME_CYC);

        // Overflow: DEPTH+2 bytes with valid held high
        saw_full     = 1'b0;
        rose_checked = 1'b0;
        valid_i      = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) begin
            data_i = 8'($urandom);
            n = 0;
            while (!ready_o && n < 4 * FRAME_CYC) begin
                if (!saw_full) begin
                    saw_full = 1'b1;
                    check("level_at_full", level_o, DEPTH);
                end
                tick();
                n++;
                if (ready_o && !rose_checked) begin
                    rose_checked = 1'b1;
                    check("level_after_full_pop", level_o, DEPTH - 1);
                end
            end
            tick();
        end
        valid_i = 1'b0;
        check("saw_full", saw_full, 1);
        check("saw_ready_return", rose_checked, 1);
        drain((DEPTH + 4) * FRAME_CYC);

        // Randomized traffic with varying offered load
        for (int k = 0; k < 3000; k++) begin
            rate = (k / 500) % 3 == 0 ? 80 : ((k / 500) % 3 == 1 ? 4 : 30);
            if ($urandom_range(0, 99) < rate) begin
                valid_i = 1'b1;
                data_i  = 8'($urandom);
            end else begin
                valid_i = 1'b0;
            end
            tick();
        end
        valid_i = 1'b0;
        drain((DEPTH + 4) * FRAME_CYC);

        // Reset mid-DATA of 0x00 with four bytes queued
        valid_i = 1'b1;
        data_i  = 8'h00;
        tick();
        for (int k = 0; k < 4; k++) begin
            data_i = 8'($urandom_range(1, 255));
            tick();
        end
        valid_i = 1'b0;
        check("queued_before_reset", level_o, 4);
        wait_fall(lat);
        repeat (3 * DIV) tick();
        check("tx_mid_data", tx_o, 0);
        rst_i = 1'b1;
        #1;
        check("async_rst_tx", tx_o, 1);
        check("async_rst_level", level_o, 0);
        check("async_rst_ready", ready_o, 1);
        check("async_rst_busy", busy_o, 0);
        tick();
        tick();
        rst_i = 1'b0;
        zeros = 0;
        for (int k = 0; k < 2 * FRAME_CYC; k++) begin
            tick();
            if (tx_o !== 1'b1) zeros++;
        end
        check("no_frame_after_reset", zeros, 0);
        check("idle_after_reset", busy_o, 0);
        push_one(8'h81);
        wait_fall(lat);
        check("latency_after_reset", lat, 2);
        sample_frame(s);
        check("byte_after_reset", s[8:1], 8'h81);
        drain(2 * FRAME_CYC);

`ifdef UART_TX_PARITY_EN
        valid_i = 1'b1;
        data_i  = 8'h07;
        tick();
        data_i  = 8'h03;
        tick();
        valid_i = 1'b0;
        wait_fall(lat);
        prev = cyc;
        sample_frame(s);
        check("parity_0x07", s[9], 1);
        check("byte_0x07", s[8:1], 8'h07);
        wait_fall(lat);
        check("parity_frame_len", cyc - prev, 11 * DIV);
        sample_frame(s);
        check("parity_0x03", s[9], 0);
        check("stop_0x03", s[10], 1);
        drain(2 * FRAME_CYC);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
